// File: rtl/tx4ph_sender_pkg.sv
// -----------------------------------------------------------------------------
// tx4ph_sender_pkg
// Shared definitions for the 4-phase bundled-data sender: the default data MSB
// index and the 2-bit encoding of the handshake FSM states.
// -----------------------------------------------------------------------------
package tx4ph_sender_pkg;

  // Default MSB index of the data word (word width is DATA_MSB+1).
  localparam int DATA_MSB = 7;

  // Handshake FSM states. The encodings are fixed so that the sender and a
  // matching receiver agree on state values in debug views.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_e;

endpackage

// File: rtl/tx4ph_sender_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous control bit. Used for the
// ack input of the sender and equally usable on the req input of a receiver.
//
// Ports:
//   clk   - sampling clock, rising edge
//   reset - asynchronous, active-low reset (both stages cleared to 0)
//   d     - asynchronous input bit
//   q     - synchronised output (second stage)
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic stage1;  // may go metastable; only ever read by stage2

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, giving a true two-stage shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/tx4ph_sender.sv
// -----------------------------------------------------------------------------
// tx4ph_sender
// Sends locally produced words to a remote receiver over a 4-phase
// (return-to-zero) bundled-data handshake. Words are buffered in a small FIFO;
// the handshake FSM pops one word, holds it on data for a setup cycle, raises
// req, waits for the synchronised ack to rise, drops req, and waits for the
// ack to fall before starting the next word.
//
// Parameters:
//   DATA_MSB   - MSB index of the data word
//   FIFO_DEPTH - input buffer entries (power of two, >= 2)
//
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-low reset
//   vi    - local word valid (written when vi & rdy at a clock edge)
//   sdata - local word
//   rdy   - buffer not full
//   ack   - 4-phase acknowledge from the receiver (asynchronous)
//   req   - 4-phase request to the receiver (registered)
//   data  - bundled data to the receiver (registered)
//   snt   - one-cycle pulse for each word acknowledged by the receiver
//   busy  - a transfer is in progress or words are buffered
// -----------------------------------------------------------------------------
module tx4ph_sender #(
  parameter int DATA_MSB   = tx4ph_sender_pkg::DATA_MSB,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vi,
  input  logic [DATA_MSB:0] sdata,
  output logic              rdy,
  input  logic              ack,
  output logic              req,
  output logic [DATA_MSB:0] data,
  output logic              snt,
  output logic              busy
);

  import tx4ph_sender_pkg::state_e;
  import tx4ph_sender_pkg::IDLE;
  import tx4ph_sender_pkg::SETUP;
  import tx4ph_sender_pkg::REQ_HI;
  import tx4ph_sender_pkg::REQ_LO;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Ack synchroniser: a2 is the only ack view the FSM uses; a2d delays it by
  // one cycle so a rising a2 can be detected for the snt pulse.
  // ---------------------------------------------------------------------------
  logic a2;
  logic a2d;

  sync2 u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack),
    .q     (a2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) a2d <= 1'b0;
    else        a2d <= a2;
  end

  assign snt = a2 & ~a2d;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_MSB:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;

  assign rdy  = (count != FULL);
  assign push = vi & rdy;

  // NOTE: storage has no reset; emptiness is tracked by pointers and count
  // alone, so stale contents are never read and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= sdata;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two. A push and
  // a pop on the same edge leave count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  state_e state_q;
  state_e state_d;
  logic   req_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req     <= 1'b0;
      data    <= '0;
    end else begin
      state_q <= state_d;
      req     <= req_d;
      // data only ever changes when a word is taken from the FIFO.
      if (pop) data <= mem[rptr];
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    req_d   = req;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        // A high a2 here is a stale ack (e.g. held through reset); starting a
        // transfer would let it be mistaken for this word's acknowledge.
        if ((count != '0) && !a2) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        req_d   = 1'b1;
        state_d = REQ_HI;
      end
      REQ_HI: begin
        if (a2) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        req_d = 1'b0;
        if (!a2) state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE) || (count != '0);

endmodule

// File: tb/tb_tx4ph_sender.sv
// -----------------------------------------------------------------------------
// tb_tx4ph_sender
// Self-checking bench for tx4ph_sender (DATA_MSB=7, FIFO_DEPTH=2). A reference
// model of the handshake is stepped on every rising edge and the DUT outputs
// are compared with it on every falling edge. A receiver model answers req
// with a programmable (or random) delay, or holds ack at a forced level.
// Words accepted by the model are compared, in order, with the words the DUT
// presented while snt was high.
// -----------------------------------------------------------------------------
module tb_tx4ph_sender;

  localparam int DEPTH = 2;
  localparam int LIMIT = 1000;

  logic       clk;
  logic       reset;
  logic       vi;
  logic [7:0] sdata;
  logic       rdy;
  logic       ack;
  logic       req;
  logic [7:0] data;
  logic       snt;
  logic       busy;

  tx4ph_sender #(.DATA_MSB(7), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .vi    (vi),
    .sdata (sdata),
    .rdy   (rdy),
    .ack   (ack),
    .req   (req),
    .data  (data),
    .snt   (snt),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (stepped on every rising edge)
  // Phase numbering: 0 idle, 1 setup, 2 req high, 3 req low.
  // ---------------------------------------------------------------------------
  int         m_phase = 0;
  bit         m_a1    = 0;
  bit         m_a2    = 0;
  bit         m_a2d   = 0;
  bit         m_req   = 0;
  logic [7:0] m_data  = 8'h00;
  logic [7:0] mq[$];
  logic [7:0] acc_q[$];
  logic [7:0] got_q[$];

  initial begin
    bit a2o;
    int sz;
    bit take;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_phase = 0;
        m_a1 = 0; m_a2 = 0; m_a2d = 0;
        m_req = 0;
        m_data = 8'h00;
        mq.delete();
        acc_q.delete();
      end else begin
        a2o  = m_a2;
        sz   = mq.size();
        take = (m_phase == 0) && (sz > 0) && !a2o;
        case (m_phase)
          0: if (take) m_phase = 1;
          1: begin m_phase = 2; m_req = 1; end
          2: if (a2o) begin m_phase = 3; m_req = 0; end
          default: if (!a2o) m_phase = 0;
        endcase
        if (take) m_data = mq.pop_front();
        if (vi && (sz < DEPTH)) begin
          mq.push_back(sdata);
          acc_q.push_back(sdata);
        end
        m_a2d = m_a2;
        m_a2  = m_a1;
        m_a1  = ack;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare (falling edge)
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_rdy",  rdy,  1'b1);
        check("rst_req",  req,  1'b0);
        check("rst_data", data, 8'h00);
        check("rst_snt",  snt,  1'b0);
        check("rst_busy", busy, 1'b0);
        got_q.delete();
      end else begin
        check("rdy",  rdy,  (mq.size() < DEPTH));
        check("req",  req,  m_req);
        check("data", data, m_data);
        check("snt",  snt,  m_a2 & ~m_a2d);
        check("busy", busy, (m_phase != 0) || (mq.size() != 0));
        if (snt && req) got_q.push_back(data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver model: follows req after a delay, or holds ack at a forced level.
  // Acts 1 time unit after the falling edge, so ack is asynchronous to clk.
  // ---------------------------------------------------------------------------
  bit ack_follow = 1;
  bit ack_force  = 0;
  bit rand_dly   = 0;
  int ack_dly    = 0;

  initial begin
    int cnt;
    int cur_dly;
    cnt = 0;
    cur_dly = 0;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (ack_follow) begin
        if (!rand_dly) cur_dly = ack_dly;
        if (req !== ack) begin
          if (cnt >= cur_dly) begin
            ack = req;
            cnt = 0;
            if (rand_dly) cur_dly = $urandom_range(0, 4);
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        ack = ack_force;
        cnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called aligned to a falling edge)
  // ---------------------------------------------------------------------------
  int base_g = 0;
  int base_a = 0;

  task automatic push_word(input logic [7:0] w);
    bit ok;
    int i;
    ok = 0;
    i  = 0;
    vi = 1'b1;
    sdata = w;
    while (!ok && i < LIMIT) begin
      ok = rdy;
      @(negedge clk);
      i++;
    end
    vi = 1'b0;
    check("push_timeout", i >= LIMIT, 1'b0);
  endtask

  task automatic drain(input string name);
    int i;
    i  = 0;
    vi = 1'b0;
    while (!(busy == 1'b0 && req == 1'b0 && ack == 1'b0) && i < LIMIT) begin
      @(negedge clk);
      i++;
    end
    check({name, "_drain_timeout"}, i >= LIMIT, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] got_at(input int k);
    if (base_g + k < got_q.size()) return got_q[base_g + k];
    return 8'hxx;
  endfunction

  task automatic check_lists(input string name);
    int ng;
    int na;
    ng = got_q.size() - base_g;
    na = acc_q.size() - base_a;
    check({name, "_len"}, ng, na);
    for (int i = 0; i < ng && i < na; i++)
      check({name, "_word"}, got_q[base_g + i], acc_q[base_a + i]);
    base_g = got_q.size();
    base_a = acc_q.size();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit seen;
    int i;
    vi = 1'b0;
    sdata = 8'h00;
    reset = 1'b0;

    repeat (3) @(negedge clk);
    check("init_rdy",  rdy,  1'b1);
    check("init_req",  req,  1'b0);
    check("init_busy", busy, 1'b0);
    check("init_data", data, 8'h00);
    #2 reset = 1'b1;

    // ---- single word with a 3-cycle receiver --------------------------------
    @(negedge clk);
    ack_follow = 1; ack_dly = 3;
    vi = 1'b1; sdata = 8'hA5;
    @(negedge clk);
    vi = 1'b0;
    check("single_busy",    busy, 1'b1);
    check("single_req_wr",  req,  1'b0);
    @(negedge clk);
    check("single_data",    data, 8'hA5);
    check("single_req_set", req,  1'b0);
    @(negedge clk);
    check("single_req_hi",  req,  1'b1);
    drain("single");
    check("single_cnt",     got_q.size() - base_g, 1);
    check("single_word0",   got_at(0), 8'hA5);
    check("single_req_end", req,  1'b0);
    check("single_idle",    busy, 1'b0);
    check_lists("single");

    // ---- fill with ack held high: third word dropped ------------------------
    ack_follow = 0; ack_force = 1;
    repeat (4) @(negedge clk);
    push_word(8'h01);
    push_word(8'h02);
    check("fill_rdy_lo", rdy, 1'b0);
    vi = 1'b1; sdata = 8'h03;
    @(negedge clk);
    vi = 1'b0;
    check("fill_rdy_still", rdy,  1'b0);
    check("fill_req_wait",  req,  1'b0);
    check("fill_busy",      busy, 1'b1);
    ack_follow = 1; ack_dly = 1;
    drain("fill");
    check("fill_cnt",   got_q.size() - base_g, 2);
    check("fill_word0", got_at(0), 8'h01);
    check("fill_word1", got_at(1), 8'h02);
    check_lists("fill");

    // ---- vi held while full, then a pop frees a slot ------------------------
    ack_follow = 0; ack_force = 1;
    repeat (4) @(negedge clk);
    push_word(8'h11);
    push_word(8'h12);
    check("full_rdy_lo", rdy, 1'b0);
    ack_follow = 1; ack_dly = 1;
    push_word(8'h13);
    drain("full");
    check("full_cnt",   got_q.size() - base_g, 3);
    check("full_word0", got_at(0), 8'h11);
    check("full_word1", got_at(1), 8'h12);
    check("full_word2", got_at(2), 8'h13);
    check_lists("full");

    // ---- stale ack held through reset release -------------------------------
    ack_follow = 0; ack_force = 1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    base_g = 0; base_a = 0;
    @(negedge clk);
    push_word(8'h5A);
    repeat (10) @(negedge clk);
    check("stale_req_wait", req,  1'b0);
    check("stale_busy",     busy, 1'b1);
    ack_force = 0;
    repeat (2) @(negedge clk);
    check("stale_req_lo2", req, 1'b0);
    repeat (2) @(negedge clk);
    check("stale_req_hi",  req, 1'b1);
    ack_follow = 1; ack_dly = 2;
    drain("stale");
    check("stale_word0", got_at(0), 8'h5A);
    check_lists("stale");

    // ---- reset while req is high --------------------------------------------
    ack_follow = 1; ack_dly = 5;
    push_word(8'h3C);
    push_word(8'h3D);
    i = 0;
    while (req !== 1'b1 && i < LIMIT) begin
      @(negedge clk);
      i++;
    end
    check("rstmid_req_timeout", i >= LIMIT, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("rstmid_req_imm",  req,  1'b0);
    check("rstmid_rdy_imm",  rdy,  1'b1);
    check("rstmid_busy_imm", busy, 1'b0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= snt;
    end
    #2 reset = 1'b1;
    base_g = 0; base_a = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= snt;
    end
    check("rstmid_no_snt", seen, 1'b0);
    check("rstmid_empty",  busy, 1'b0);
    drain("rstmid");
    check_lists("rstmid");

    // ---- back-to-back stream against a zero-delay receiver ------------------
    ack_follow = 1; ack_dly = 0;
    for (int k = 0; k < 16; k++) push_word(8'(8'h40 + k * 3));
    drain("b2b");
    check("b2b_cnt",    got_q.size() - base_g, 16);
    check("b2b_first",  got_at(0),  8'h40);
    check("b2b_last",   got_at(15), 8'h6D);
    check_lists("b2b");

    // ---- random traffic against a random-delay receiver ---------------------
    rand_dly = 1;
    for (int c = 0; c < 400; c++) begin
      vi    = 1'($urandom_range(0, 1));
      sdata = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    vi = 1'b0;
    rand_dly = 0; ack_dly = 0;
    drain("rand");
    check_lists("rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
